// File: rtl/alu_mult_seq_pkg.sv
// Shared definitions for the sequential multiplier and the ALU it drives.
//   - ALUOp encodings understood by the negedge-clocked ALU (adder).
//   - State encoding for alu_mult_seq.
package alu_mult_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SHL  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_t;

  // Where the iteration goes once the remaining multiplier is known:
  // nothing left -> DONE, low bit set -> ADD, otherwise just shift.
  function automatic mult_state_t step_state(input logic [31:0] m);
    if (m == 32'd0)
      return ST_DONE;
    else if (m[0])
      return ST_ADD;
    else
      return ST_SHL;
  endfunction

endpackage

// File: rtl/adder.sv
// Negedge-clocked ALU used by the execute stage and by alu_mult_seq.
// Ports:
//   clock   : system clock; the result register updates on negedge
//   rs, rt  : 32-bit operands
//   aluop   : 4-bit operation select (encodings in alu_mult_seq_pkg)
//   shamt   : 5-bit shift amount, applied to rt for shifts
//   result  : registered 32-bit result
module adder
  import alu_mult_seq_pkg::*;
(
  input  logic        clock,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [3:0]  aluop,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);

  logic [31:0] res_c;

  always_comb begin
    res_c = 32'd0;
    case (aluop)
      OP_ADD:  res_c = rs + rt;
      OP_SUB:  res_c = rs - rt;
      OP_AND:  res_c = rs & rt;
      OP_OR:   res_c = rs | rt;
      OP_NOR:  res_c = ~(rs | rt);
      OP_SLT:  res_c = {31'd0, ($signed(rs) < $signed(rt))};
      OP_SLL:  res_c = rt << shamt;
      OP_SRL:  res_c = rt >> shamt;
      OP_SRA:  res_c = $unsigned($signed(rt) >>> shamt);
      default: res_c = 32'd0;
    endcase
  end

  always_ff @(negedge clock) begin
    result <= res_c;
  end

endmodule

// File: rtl/alu_mult_seq.sv
// Sequential unsigned 32x32 multiplier (low 32 bits of the product).
// Shift-and-add: each ADD or SLL step is issued to the external negedge
// ALU, one operation per clock; the multiplier is shifted internally.
//
// Handshake: ready=1 only in IDLE; a request is accepted on a posedge with
// start=1 and ready=1. done is a one-cycle pulse in the DONE state; product
// is registered at the end of that cycle and held until the next accept.
//
// Ports:
//   clock, reset_n      : clock, synchronous active-low reset
//   start, op_a, op_b   : request and operands (latched on accept)
//   ready, done, product: status and result
//   alu_rs/rt/op/shamt  : ALU drive, decoded from the registered state
//   alu_result          : ALU result, captured on the posedge after use
module alu_mult_seq
  import alu_mult_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result
);

  mult_state_t state, state_nxt;
  logic [31:0] acc, mcand, mplier;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = step_state(op_b);
      ST_ADD:  state_nxt = ST_SHL;
      ST_SHL:  state_nxt = step_state(mplier >> 1);
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are a pure decode of the registered state so the ALU sees
  // stable operands from the posedge that enters the state.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    alu_rs    = 32'd0;
    alu_rt    = 32'd0;
    alu_op    = OP_NOP;
    alu_shamt = 5'd0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_ADD: begin
        alu_rs = acc;
        alu_rt = mcand;
        alu_op = OP_ADD;
      end
      ST_SHL: begin
        alu_rt    = mcand;
        alu_op    = OP_SLL;
        alu_shamt = 5'd1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      product <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= 32'd0;
          end
        end
        ST_ADD: acc <= alu_result;
        ST_SHL: begin
          mcand  <= alu_result;
          mplier <= mplier >> 1;
        end
        ST_DONE: product <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Testbench for alu_mult_seq wired to the adder ALU.
module tb_alu_mult_seq;
  import alu_mult_seq_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        ready, done;
  logic [31:0] product;
  logic [31:0] alu_rs, alu_rt, alu_result;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;

  int checks = 0;
  int errors = 0;

  logic [3:0]  op_log    [0:80];
  logic [4:0]  shamt_log [0:80];
  logic [31:0] rs_log    [0:80];
  logic [31:0] rt_log    [0:80];

  alu_mult_seq dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .done(done), .product(product),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result)
  );

  adder alu (
    .clock(clock), .rs(alu_rs), .rt(alu_rt), .aluop(alu_op),
    .shamt(alu_shamt), .result(alu_result)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starting one cycle after the accepting edge, log ALU drive each cycle
  // until done; return the latency (0 on timeout). Does not touch start.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 80; c++) begin
      op_log[c]    = alu_op;
      shamt_log[c] = alu_shamt;
      rs_log[c]    = alu_rs;
      rt_log[c]    = alu_rt;
      if (done) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  task automatic do_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input int exp_lat);
    int lat;
    int w;
    w = 0;
    while (!ready && w < 100) begin
      step();
      w++;
    end
    chk({name, "_ready_before"}, {31'd0, ready}, 32'd1);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    step();
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    chk({name, "_ready_busy"}, {31'd0, ready}, (exp_lat == 1) ? 32'd0 : 32'd0);
    wait_done(lat);
    chk({name, "_latency"}, lat, exp_lat);
    step();
    chk({name, "_done_single"}, {31'd0, done}, 32'd0);
    chk({name, "_ready_after"}, {31'd0, ready}, 32'd1);
    chk({name, "_product"}, product, prod);
  endtask

  initial begin
    int lat;
    int dones;
    reset_n = 1'b0;
    start   = 1'b0;
    op_a    = 32'd0;
    op_b    = 32'd0;

    // Latency = popcount(b) + (msb index + 1) + 1
    vecs.push_back('{32'd3,          32'd5,          32'd15,         6});
    vecs.push_back('{32'h1234,       32'd0,          32'd0,          1});
    vecs.push_back('{32'd0,          32'd7,          32'd0,          7});
    vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   65});
    vecs.push_back('{32'd12345,      32'd6789,       32'd83810205,   20});
    vecs.push_back('{32'h00010000,   32'h00010000,   32'd0,          19});
    vecs.push_back('{32'hDEADBEEF,   32'd1,          32'hDEADBEEF,   3});
    vecs.push_back('{32'h80000000,   32'd2,          32'd0,          4});
    vecs.push_back('{32'd100,        32'd200,        32'd20000,      12});

    repeat (3) step();
    chk("reset_ready",   {31'd0, ready}, 32'd1);
    chk("reset_done",    {31'd0, done},  32'd0);
    chk("reset_alu_op",  {28'd0, alu_op}, 32'd0);
    chk("reset_product", product, 32'd0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_alu_rs", alu_rs, 32'd0);

    foreach (vecs[i])
      do_mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat);

    // 3*5: ADD,SHL,SHL,ADD,SHL,DONE with operand flow through the ALU
    do_mult("seq3x5", 32'd3, 32'd5, 32'd15, 6);
    chk("seq_op1", {28'd0, op_log[1]}, {28'd0, OP_ADD});
    chk("seq_op2", {28'd0, op_log[2]}, {28'd0, OP_SLL});
    chk("seq_op3", {28'd0, op_log[3]}, {28'd0, OP_SLL});
    chk("seq_op4", {28'd0, op_log[4]}, {28'd0, OP_ADD});
    chk("seq_op5", {28'd0, op_log[5]}, {28'd0, OP_SLL});
    chk("seq_op6", {28'd0, op_log[6]}, {28'd0, OP_NOP});
    chk("seq_sh1", {27'd0, shamt_log[1]}, 32'd0);
    chk("seq_sh2", {27'd0, shamt_log[2]}, 32'd1);
    chk("seq_sh5", {27'd0, shamt_log[5]}, 32'd1);
    chk("seq_rs1", rs_log[1], 32'd0);
    chk("seq_rt1", rt_log[1], 32'd3);
    chk("seq_rt3", rt_log[3], 32'd6);
    chk("seq_rs4", rs_log[4], 32'd3);
    chk("seq_rt4", rt_log[4], 32'd12);
    chk("seq_rt5", rt_log[5], 32'd12);

    // start held high through a 7*9 operation: one accept, one done
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'd9;
    step();
    dones = 0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("cont_ready_c%0d", c), {31'd0, ready}, 32'd0);
      if (done) dones++;
      if (c == 7) chk("cont_done_c7", {31'd0, done}, 32'd1);
      op_a = 32'd2;
      op_b = 32'd3;
      step();
    end
    chk("cont_done_count", dones, 32'd1);
    chk("cont_ready_idle", {31'd0, ready}, 32'd1);
    chk("cont_product", product, 32'd63);
    // Still high in IDLE: 2*3 accepted now
    step();
    start = 1'b0;
    wait_done(lat);
    chk("cont_next_latency", lat, 32'd5);
    step();
    chk("cont_next_product", product, 32'd6);

    // Reset in the middle of 100*200
    start = 1'b1;
    op_a  = 32'd100;
    op_b  = 32'd200;
    step();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 5; c++) begin
      if (done) dones++;
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_mid_ready",   {31'd0, ready}, 32'd1);
    chk("rst_mid_alu_op",  {28'd0, alu_op}, 32'd0);
    chk("rst_mid_product", product, 32'd0);
    for (int c = 1; c <= 15; c++) begin
      if (done) dones++;
      step();
    end
    chk("rst_mid_no_done", dones, 32'd0);
    chk("rst_mid_product_held", product, 32'd0);
    do_mult("after_rst", 32'd6, 32'd7, 32'd42, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
